// File: rtl/si1143_gesture_decoder.sv
// Si1143 proximity gesture decoder: classifies left/right/up/down swipes and taps
// from the order in which the PS1/PS2/PS3 channels cross the enter threshold.
module si1143_gesture_decoder #(
    parameter int              PS_W      = 16,
    parameter logic [PS_W-1:0] ENTER_THR = PS_W'(1200),
    parameter logic [PS_W-1:0] EXIT_THR  = PS_W'(800),
    parameter int              TS_W      = 8,
    parameter int              MIN_DT    = 2,
    parameter int              TIMEOUT   = 200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_valid,
    input  logic [PS_W-1:0] ps1,
    input  logic [PS_W-1:0] ps2,
    input  logic [PS_W-1:0] ps3,
    output logic            presence,
    output logic            gesture_valid,
    output logic [2:0]      gesture_code,
    output logic [7:0]      gesture_count,
    output logic            timeout_flag
);
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD, S_DECIDE} state_t;

    localparam logic [2:0] CODE_LEFT  = 3'd1;
    localparam logic [2:0] CODE_RIGHT = 3'd2;
    localparam logic [2:0] CODE_UP    = 3'd3;
    localparam logic [2:0] CODE_DOWN  = 3'd4;
    localparam logic [2:0] CODE_TAP   = 3'd5;
    localparam logic [TS_W-1:0]        TIMEOUT_N = TS_W'(TIMEOUT);
    localparam logic signed [TS_W:0]   MIN_DT_S  = (TS_W+1)'(MIN_DT);

    state_t                 state_q, state_d;
    logic [TS_W-1:0]        n_q, n_d, n_inc;
    logic [2:0][TS_W-1:0]   t_q, t_d;
    logic [2:0]             v_q, v_d;
    logic                   presence_q, presence_d;
    logic                   gesture_valid_q, gesture_valid_d;
    logic [2:0]             gesture_code_q, gesture_code_d;
    logic [7:0]             gesture_count_q, gesture_count_d;
    logic                   timeout_flag_q, timeout_flag_d;

    logic [2:0][PS_W-1:0]   ps;
    logic [2:0]             covered, clear;
    logic [TS_W-1:0]        tm;
    logic signed [TS_W:0]   dx, dy, adx, ady, mag;
    logic                   dx_ok, dy_ok, two_plus, horiz;
    logic [2:0]             code_sel;

    assign ps = {ps3, ps2, ps1};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            covered[i] = ps[i] >= ENTER_THR;
            clear[i]   = ps[i] < EXIT_THR;
        end
    end

    assign n_inc = (n_q == {TS_W{1'b1}}) ? n_q : n_q + 1'b1;

    // Crossing-order classification; only meaningful while in DECIDE.
    always_comb begin
        dx_ok    = v_q[0] & v_q[1];
        dy_ok    = v_q[2] & (v_q[0] | v_q[1]);
        two_plus = (v_q[0] & v_q[1]) | (v_q[0] & v_q[2]) | (v_q[1] & v_q[2]);
        if (dx_ok)       tm = (t_q[0] < t_q[1]) ? t_q[0] : t_q[1];
        else if (v_q[0]) tm = t_q[0];
        else             tm = t_q[1];
        dx    = $signed({1'b0, t_q[1]}) - $signed({1'b0, t_q[0]});
        dy    = $signed({1'b0, tm}) - $signed({1'b0, t_q[2]});
        adx   = dx[TS_W] ? -dx : dx;
        ady   = dy[TS_W] ? -dy : dy;
        horiz = dx_ok && (!dy_ok || adx >= ady);
        mag   = horiz ? adx : ady;
        code_sel = CODE_TAP;
        if (mag >= MIN_DT_S) begin
            if (horiz) code_sel = dx[TS_W] ? CODE_LEFT : CODE_RIGHT;
            else       code_sel = dy[TS_W] ? CODE_UP : CODE_DOWN;
        end
    end

    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        t_d             = t_q;
        v_d             = v_q;
        gesture_valid_d = 1'b0;
        gesture_code_d  = gesture_code_q;
        gesture_count_d = gesture_count_q;
        timeout_flag_d  = timeout_flag_q;
        case (state_q)
            S_IDLE: begin
                if (sample_valid && |covered) begin
                    state_d = S_TRACK;
                    n_d     = '0;
                    t_d     = '0;
                    v_d     = covered;
                end
            end
            S_TRACK: begin
                if (sample_valid) begin
                    n_d = n_inc;
                    for (int i = 0; i < 3; i++) begin
                        if (covered[i] && !v_q[i]) begin
                            t_d[i] = n_inc;
                            v_d[i] = 1'b1;
                        end
                    end
                    // All-clear wins over a timeout landing on the same sample.
                    if (&clear) begin
                        state_d = S_DECIDE;
                    end else if (n_inc >= TIMEOUT_N) begin
                        state_d        = S_HOLD;
                        timeout_flag_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (sample_valid && &clear) state_d = S_IDLE;
            end
            S_DECIDE: begin
                state_d = S_IDLE;
                if (two_plus) begin
                    gesture_valid_d = 1'b1;
                    gesture_code_d  = code_sel;
                    gesture_count_d = gesture_count_q + 8'd1;
                    timeout_flag_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        presence_d = (state_d == S_TRACK) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            n_q             <= '0;
            t_q             <= '0;
            v_q             <= '0;
            presence_q      <= 1'b0;
            gesture_valid_q <= 1'b0;
            gesture_code_q  <= '0;
            gesture_count_q <= '0;
            timeout_flag_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            t_q             <= t_d;
            v_q             <= v_d;
            presence_q      <= presence_d;
            gesture_valid_q <= gesture_valid_d;
            gesture_code_q  <= gesture_code_d;
            gesture_count_q <= gesture_count_d;
            timeout_flag_q  <= timeout_flag_d;
        end
    end

    assign presence      = presence_q;
    assign gesture_valid = gesture_valid_q;
    assign gesture_code  = gesture_code_q;
    assign gesture_count = gesture_count_q;
    assign timeout_flag  = timeout_flag_q;
endmodule
